// File: rtl/ahb_bus_master.sv
// rtl/ahb_bus_master.sv - AHB incrementing-burst bus master with retry/split/error handling
module ahb_bus_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic        cmd_write,
    input  logic        cmd_lock,
    input  logic [31:0] wdata,
    output logic        wdata_ack,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        done_err,
    output logic        HBUSREQ,
    output logic        HLOCK,
    input  logic        HGRANT,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_RESP2, S_FIN} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    state_t      r_state;
    logic [31:0] r_haddr;
    logic [31:0] r_dp_addr;
    logic [4:0]  r_alen;
    logic [4:0]  r_dlen;
    logic [1:0]  r_trans;
    logic        r_dp;
    logic        r_nonseq;
    logic        r_write;
    logic        r_lock;
    logic        r_busreq;
    logic        r_hlock;
    logic        r_cmd_ready;
    logic        r_done;
    logic        r_done_err;
    logic        r_wdata_ack;
    logic        r_rdata_valid;
    logic [31:0] r_rdata;

    logic        w_acc;
    logic        w_dfin;
    logic        w_rewind;
    logic [31:0] w_next_addr;
    logic [4:0]  w_alen_n;
    logic [4:0]  w_dlen_n;
    logic [4:0]  w_cmd_len;
    logic        w_seq_ok;

    // r_alen counts address phases still to be accepted, r_dlen data phases still to finish OKAY.
    // A RETRY/SPLIT rewinds the address to the failed data phase and re-arms every unfinished transfer.
    assign w_acc       = HREADY & r_trans[1];
    assign w_dfin      = HREADY & r_dp & (r_state == S_XFER);
    assign w_rewind    = (r_state == S_RESP2) & HREADY & (HRESP != RSP_ERROR);
    assign w_next_addr = w_rewind ? r_dp_addr : (w_acc ? r_haddr + 32'd4 : r_haddr);
    assign w_alen_n    = w_rewind ? r_dlen : r_alen - {4'd0, w_acc};
    assign w_dlen_n    = r_dlen - {4'd0, w_dfin};
    assign w_cmd_len   = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
    assign w_seq_ok    = !r_nonseq && (w_next_addr[9:0] != 10'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= S_IDLE;
            r_haddr       <= 32'd0;
            r_dp_addr     <= 32'd0;
            r_alen        <= 5'd0;
            r_dlen        <= 5'd0;
            r_trans       <= TR_IDLE;
            r_dp          <= 1'b0;
            r_nonseq      <= 1'b1;
            r_write       <= 1'b0;
            r_lock        <= 1'b0;
            r_busreq      <= 1'b0;
            r_hlock       <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_done        <= 1'b0;
            r_done_err    <= 1'b0;
            r_wdata_ack   <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= 32'd0;
        end else begin
            r_wdata_ack   <= 1'b0;
            r_rdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= S_REQ;
                        r_haddr     <= cmd_addr & ~32'd3;
                        r_alen      <= w_cmd_len;
                        r_dlen      <= w_cmd_len;
                        r_write     <= cmd_write;
                        r_lock      <= cmd_lock;
                        r_busreq    <= 1'b1;
                        r_hlock     <= cmd_lock;
                        r_cmd_ready <= 1'b0;
                        r_nonseq    <= 1'b1;
                        r_dp        <= 1'b0;
                    end
                end
                S_REQ, S_XFER, S_RESP2: begin
                    if (r_state == S_XFER && !HREADY && r_dp && HRESP != RSP_OKAY) begin
                        r_state  <= S_RESP2;
                        r_trans  <= TR_IDLE;
                        r_nonseq <= 1'b1;
                    end else if (r_state == S_RESP2 && HREADY && HRESP == RSP_ERROR) begin
                        r_state    <= S_FIN;
                        r_trans    <= TR_IDLE;
                        r_dp       <= 1'b0;
                        r_busreq   <= 1'b0;
                        r_hlock    <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_err <= 1'b1;
                    end else if (HREADY) begin
                        if (w_dfin) begin
                            if (r_write) begin
                                r_wdata_ack <= 1'b1;
                            end else begin
                                r_rdata       <= HRDATA;
                                r_rdata_valid <= 1'b1;
                            end
                        end
                        if (w_rewind) begin
                            r_busreq <= 1'b1;
                            r_hlock  <= r_lock;
                        end
                        r_dp <= w_acc;
                        if (w_acc) begin
                            r_dp_addr <= r_haddr;
                        end
                        r_haddr <= w_next_addr;
                        r_alen  <= w_alen_n;
                        r_dlen  <= w_dlen_n;
                        if (w_dlen_n == 5'd0) begin
                            r_state    <= S_FIN;
                            r_trans    <= TR_IDLE;
                            r_busreq   <= 1'b0;
                            r_hlock    <= 1'b0;
                            r_done     <= 1'b1;
                            r_done_err <= 1'b0;
                        end else if (HGRANT && w_alen_n != 5'd0) begin
                            r_state  <= S_XFER;
                            r_trans  <= w_seq_ok ? TR_SEQ : TR_NONSEQ;
                            r_nonseq <= 1'b0;
                            r_busreq <= (w_alen_n > 5'd1);
                            r_hlock  <= (w_alen_n > 5'd1) && r_lock;
                        end else begin
                            r_trans <= TR_IDLE;
                            if (!HGRANT) begin
                                r_nonseq <= 1'b1;
                            end
                            if (r_state == S_RESP2) begin
                                r_state <= S_XFER;
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_done_err  <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign wdata_ack   = r_wdata_ack;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign done_err    = r_done_err;
    assign HBUSREQ     = r_busreq;
    assign HLOCK       = r_hlock;
    assign HADDR       = r_haddr;
    assign HTRANS      = r_trans;
    assign HWRITE      = r_write;
    assign HWDATA      = (r_dp && r_write) ? wdata : 32'd0;
endmodule
